seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//   Reads the multiplexed 3-digit seven-segment bus (anodes/cathodes) driven by the reflex-timer
//   display logic and reconstructs the 12-bit hex value being shown.
//   Sits on the bench/board-monitor side of the display bus.
//   Used for self-check of displayed reflex times and for on-board loopback of time_display.
// PARAMETERS
//   SETTLE_CYCLES  4        consecutive clk cycles {anodes,cathodes} must be unchanged before a digit is sampled (>=1)
//   TIMEOUT_CYCLES 131072   clk cycles without a legal anode change before stale asserts (>= 3*0x10000 scan period / 2)
// PORTS
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-low reset
//   anodes       in   3   digit enables, active-low, one-cold (011=digit2, 101=digit1, 110=digit0)
//   cathodes     in   8   segment drive, active-low; bit7 = dp (ignored), bits[6:0] = g..a
//   frame_value  out  12  last complete decoded value {digit2,digit1,digit0}
//   frame_valid  out  1   one-cycle pulse when frame_value updates
//   digit_mask   out  3   digits captured in current, incomplete frame (bit2=digit2 .. bit0=digit0)
//   decode_err   out  1   sticky: an unrecognised segment pattern was sampled
//   stale        out  1   no legal anode change seen for TIMEOUT_CYCLES
// BEHAVIOUR
//   Reset: reset=0 at posedge clk clears frame_value=0, frame_valid=0, digit_mask=0, decode_err=0, stale=0,
//     settle counter=0, timeout counter=0, state=IDLE, sync registers=anodes 3'b111 / cathodes 8'hFF.
//     Reset mid-frame discards partially captured digits.
//   Input sync: anodes and cathodes each pass through 2 flops; all logic uses the synchronised copies (s_an, s_ca).
//   Stability: stab_cnt clears when {s_an,s_ca} differs from its previous-cycle value, else increments, saturating at SETTLE_CYCLES.
//   State machine:
//     IDLE    - s_an not legal (not 011/101/110). Go to SETTLE when s_an becomes legal.
//     SETTLE  - s_an legal, waiting. When stab_cnt reaches SETTLE_CYCLES, sample and go to HOLD.
//               Illegal s_an -> IDLE.
//     HOLD    - digit taken; ignore bus until s_an changes: new legal value -> SETTLE, illegal value -> IDLE.
//               A cathode-only change in HOLD is ignored.
//   Sample: decode s_ca[6:0]:
//     40=0  79=1  24=2  30=3  19=4  12=5  02=6  78=7  00=8  18=9  08=A  03=b  46=C  21=d  06=E  0E=F
//     Valid code: write the nibble into a shadow digit (011->[11:8], 101->[7:4], 110->[3:0]) and set the matching digit_mask bit.
//     Any other code: decode_err <= 1; shadow and digit_mask unchanged. decode_err stays set until reset.
//   Frame completion: on the cycle digit_mask becomes 3'b111:
//     - next cycle, frame_value <= shadow, frame_valid=1 for exactly one cycle, digit_mask <= 0.
//     - Re-sampling an already-captured digit before completion overwrites that shadow nibble; no extra frame.
//   Latency: bus change -> sample = 2 (sync) + SETTLE_CYCLES cycles; last sample -> frame_valid = 1 cycle.
//   Timeout: to_cnt clears on every change of s_an to a legal value, else increments (saturating).
//     stale=1 while to_cnt >= TIMEOUT_CYCLES; clears the cycle after the next legal anode change.
//     Digits already captured are kept while stale.
//   Simultaneous events: anode change on the same cycle stab_cnt reaches SETTLE_CYCLES -> change wins, no sample.
//     frame_valid and a new sample in the same cycle are both honoured; the new sample starts the next frame.
// TESTING (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64 in sim)
//   1. Scan 011/C0-hex 0x82 (6), 101/F9 (1), 110/99 (4), 20 cycles each -> frame_valid once, frame_value=12'h614, decode_err=0.
//   2. Glitch: cathodes toggle every 2 cycles for 10 cycles on digit0, then hold 0x92 -> only 5 captured, no decode_err.
//   3. Pattern 8'hFF on digit1 -> decode_err=1 sticky, digit_mask bit1 stays 0, no frame_valid until valid 101 sample.
//   4. Anodes held 3'b110 for 70 cycles -> stale=1 at cycle 64; switch to 011 -> stale=0 next cycle.
//   5. Reset (reset=0 one cycle) after two digits captured -> digit_mask=0, frame_value=0; next full scan gives a fresh frame.
//   6. Anodes 3'b100 (illegal) for 10 cycles between digits -> no sample taken; scan resumes correctly, value intact.

Source files
------------

// File: rtl/seg_scan_if.sv
// Multiplexed seven-segment display bus: active-low one-cold anodes plus
// active-low cathodes. The display logic drives it; the decoder observes it.
interface seg_scan_if;
  logic [2:0] anodes;
  logic [7:0] cathodes;

  modport master (output anodes, output cathodes);
  modport slave  (input  anodes, input  cathodes);
endinterface

// File: rtl/seg_scan_decoder.sv
// Observes a 3-digit multiplexed seven-segment bus and rebuilds the 12-bit hex
// value on display, flagging unknown segment patterns and a stalled scan.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic        clk,
    input  logic        reset,
    seg_scan_if.slave   bus,
    output logic [11:0] frame_value,
    output logic        frame_valid,
    output logic [2:0]  digit_mask,
    output logic        decode_err,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [2:0]      an_s1, s_an, an_q;
    logic [7:0]      ca_s1, s_ca, ca_q;
    logic [SW-1:0]   stab_cnt;
    logic [TW-1:0]   to_cnt;
    logic [2:0][3:0] shadow, shadow_nxt;
    logic [2:0]      mask_nxt;
    logic [2:0]      dig_sel;
    logic            an_legal, an_chg, bus_chg, sample, complete;
    logic            dec_ok;
    logic [3:0]      dec_nib;

    // Returns {recognised, nibble} for the active-low g..a segment pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40: seg_decode = {1'b1, 4'h0};
            7'h79: seg_decode = {1'b1, 4'h1};
            7'h24: seg_decode = {1'b1, 4'h2};
            7'h30: seg_decode = {1'b1, 4'h3};
            7'h19: seg_decode = {1'b1, 4'h4};
            7'h12: seg_decode = {1'b1, 4'h5};
            7'h02: seg_decode = {1'b1, 4'h6};
            7'h78: seg_decode = {1'b1, 4'h7};
            7'h00: seg_decode = {1'b1, 4'h8};
            7'h18: seg_decode = {1'b1, 4'h9};
            7'h08: seg_decode = {1'b1, 4'hA};
            7'h03: seg_decode = {1'b1, 4'hB};
            7'h46: seg_decode = {1'b1, 4'hC};
            7'h21: seg_decode = {1'b1, 4'hD};
            7'h06: seg_decode = {1'b1, 4'hE};
            7'h0E: seg_decode = {1'b1, 4'hF};
            default: seg_decode = 5'h00;
        endcase
    endfunction

    assign an_legal = (s_an == 3'b011) || (s_an == 3'b101) || (s_an == 3'b110);
    assign an_chg   = (s_an != an_q);
    assign bus_chg  = ({s_an, s_ca} != {an_q, ca_q});
    assign {dec_ok, dec_nib} = seg_decode(s_ca[6:0]);
    // One-cold anode inverted is the one-hot digit select.
    assign dig_sel  = an_legal ? ~s_an : 3'b000;
    assign complete = (digit_mask == 3'b111);
    assign stale    = (to_cnt >= TIMEOUT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (an_legal) state_nxt = SETTLE;
            SETTLE: if (!an_legal) state_nxt = IDLE;
                    else if (!an_chg && !bus_chg && stab_cnt == SETTLE_MAX) state_nxt = HOLD;
            HOLD:   if (an_chg) state_nxt = an_legal ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An anode change in the settle-done cycle suppresses the sample.
    always_comb begin
        sample = 1'b0;
        if (state == SETTLE && an_legal && !an_chg && !bus_chg && stab_cnt == SETTLE_MAX)
            sample = 1'b1;
    end

    for (genvar d = 0; d < 3; d++) begin : g_digit
        assign shadow_nxt[d] = (sample && dec_ok && dig_sel[d]) ? dec_nib : shadow[d];
    end

    // A completing frame clears the mask, but a same-cycle sample seeds the next one.
    always_comb begin
        mask_nxt = complete ? 3'b000 : digit_mask;
        if (sample && dec_ok) mask_nxt = mask_nxt | dig_sel;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an_s1       <= 3'b111;
            s_an        <= 3'b111;
            an_q        <= 3'b111;
            ca_s1       <= 8'hFF;
            s_ca        <= 8'hFF;
            ca_q        <= 8'hFF;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            shadow      <= '0;
            digit_mask  <= 3'b000;
            frame_value <= 12'h000;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            an_s1       <= bus.anodes;
            s_an        <= an_s1;
            an_q        <= s_an;
            ca_s1       <= bus.cathodes;
            s_ca        <= ca_s1;
            ca_q        <= s_ca;
            stab_cnt    <= bus_chg ? '0 : (stab_cnt == SETTLE_MAX ? stab_cnt : stab_cnt + 1'b1);
            to_cnt      <= (an_chg && an_legal) ? '0 : (to_cnt == TIMEOUT_MAX ? to_cnt : to_cnt + 1'b1);
            shadow      <= shadow_nxt;
            digit_mask  <= mask_nxt;
            frame_valid <= complete;
            if (complete) frame_value <= shadow;
            if (sample && !dec_ok) decode_err <= 1'b1;
        end
    end

endmodule
